axil_mem_slave: RTL and testbench

- Parametrised AXI4-Lite memory slave. Successor to the fixed 32-bit block-memory endpoint behind the PCIe AXI-Lite bridge master.
- Generalises data width, depth and base address.
- Adds independent AW/W acceptance, byte strobes, defined read/write collision ordering and a compile-time address range check.
- Sits directly on the bridge's M_AXI port in the user_clk domain.

---
 rtl/axil_mem_slave.sv | 122 ++++++++++++
 tb/tb_axil_mem_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_slave.sv
// rtl/axil_mem_slave.sv - AXI4-Lite memory slave with byte strobes and independent AW/W capture
// Optional decode-error range check: define AXIL_MEM_RANGE_CHECK_EN.
module axil_mem_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                s_aclk,
    input  logic                s_aresetn,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int TOP    = LSB + IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready_en;
    logic              aw_full;
    logic              aw_err;
    logic [IDX_W-1:0]  aw_idx;
    logic              w_full;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_bad, ar_bad;
    logic unused_addr_bits;

    // Only the word-index slice (and the upper bits when range checking) is decoded.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr, BASE_ADDR};

`ifdef AXIL_MEM_RANGE_CHECK_EN
    assign aw_bad = s_axi_awaddr[ADDR_W-1:TOP] != BASE_ADDR[ADDR_W-1:TOP];
    assign ar_bad = s_axi_araddr[ADDR_W-1:TOP] != BASE_ADDR[ADDR_W-1:TOP];
`else
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
`endif

    // ready_en holds all readies low during reset and for the release cycle.
    assign s_axi_awready = ready_en && !aw_full && !s_axi_bvalid;
    assign s_axi_wready  = ready_en && !w_full && !s_axi_bvalid;
    assign s_axi_arready = ready_en && !s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_full && w_full;

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            ready_en     <= 1'b0;
            aw_full      <= 1'b0;
            aw_err       <= 1'b0;
            aw_idx       <= '0;
            w_full       <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else begin
            ready_en <= 1'b1;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi_awaddr[TOP-1:LSB];
                aw_err  <= aw_bad;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= aw_err ? 2'b11 : 2'b00;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                s_axi_bresp  <= 2'b00;
            end
            // Array read uses the pre-commit contents, so a same-edge collision returns old data.
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= ar_bad ? '0 : mem[s_axi_araddr[TOP-1:LSB]];
                s_axi_rresp  <= ar_bad ? 2'b11 : 2'b00;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_aclk) begin
        if (commit && !aw_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axil_mem_slave.sv
// tb/tb_axil_mem_slave.sv - randomized self-checking bench for axil_mem_slave against a word-array model
module tb_axil_mem_slave;
    logic        clk = 1'b0;
    logic        s_aresetn;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    axil_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
        .s_aclk(clk), .s_aresetn(s_aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Presents AW and W after independent delays; response latency is counted from the later handshake.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
        int c = 0;
        int n = 0;
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        bready = 1'b1;
        while (!(aw_done && w_done) && c < 40) begin
            awvalid = !aw_done && c >= aw_dly;
            awaddr  = addr;
            wvalid  = !w_done && c >= w_dly;
            wdata   = data;
            wstrb   = strb;
            aw_go   = awvalid && awready;
            w_go    = wvalid && wready;
            @(negedge clk);
            c++;
            if (aw_go) aw_done = 1;
            if (w_go)  w_done  = 1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshake", {aw_done, w_done}, 2'b11);
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", n, 1);
        resp = bresp;
        @(negedge clk);
        check("b_cleared", bvalid, 0);
        check("aw_ready_back", {awready, wready}, 2'b11);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int c = 0;
        arvalid = 1'b1;
        araddr  = addr;
        while (!arready && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check("r_latency", rvalid, 1);
        data = rdata;
        resp = rresp;
        @(negedge clk);
        check("r_hold", {rvalid, arready, rdata}, {2'b10, data});
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_cleared", {rvalid, arready}, 2'b01);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        s_aresetn = 1'b0;
        {awvalid, wvalid, arvalid, bready, rready} = '0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 0);
        s_aresetn = 1'b1;
        #1 check("ready_low_at_release", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("ready_after_release", {awready, wready, arready}, 3'b111);

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r);
        model[32'h10 >> 2] = 32'hDEADBEEF;
        check("w10_bresp", r, 2'b00);
        do_read(32'h10, d, r);
        check("r10_data", d, 32'hDEADBEEF);
        check("r10_rresp", r, 2'b00);

        do_write(32'h20, 32'h11223344, 4'hF, 0, 0, r);
        do_write(32'h20, 32'hAABBCCDD, 4'h5, 1, 0, r);
        model[8] = 32'h11BB33DD;
        do_read(32'h20, d, r);
        check("strobe_merge", d, 32'h11BB33DD);

        // W three cycles ahead of AW, then B stalled four cycles.
        bready = 1'b0;
        wdata = 32'h0BADCAFE; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        repeat (2) begin
            check("ooo_w_held", {wready, awready, bvalid}, 3'b010);
            @(negedge clk);
        end
        awaddr = 32'h30; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("ooo_pre_commit", {bvalid, awready, wready}, 3'b000);
        @(negedge clk);
        repeat (4) begin
            check("ooo_b_stall", {bvalid, awready, wready}, 3'b100);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("ooo_b_done", {bvalid, awready, wready}, 3'b011);
        model[12] = 32'h0BADCAFE;
        do_read(32'h30, d, r);
        check("ooo_data", d, 32'h0BADCAFE);

        do_write(32'h40, 32'h1, 4'hF, 0, 0, r);
        bready = 1'b0;
        awaddr = 32'h40; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h40; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("collision_old", {bvalid, rvalid, rdata}, {2'b11, 32'h1});
        model[16] = 32'h2;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("collision_clear", {bvalid, rvalid}, 2'b00);
        do_read(32'h40, d, r);
        check("collision_new", d, 32'h2);

        do_write(32'h0, 32'h5A5A5A5A, 4'hF, 0, 2, r);
        model[0] = 32'h5A5A5A5A;
        do_write(32'h1000, 32'hCAFEF00D, 4'hF, 2, 0, r);
`ifdef AXIL_MEM_RANGE_CHECK_EN
        check("range_bresp", r, 2'b11);
        do_read(32'h1000, d, r);
        check("range_rdata", {d, r}, {32'h0, 2'b11});
`else
        check("alias_bresp", r, 2'b00);
        model[0] = 32'hCAFEF00D;
        do_read(32'h1000, d, r);
        check("alias_read", {d, r}, {32'hCAFEF00D, 2'b00});
`endif
        do_read(32'h0, d, r);
        check("word0", d, model[0]);

        for (int i = 0; i < 80; i++) begin
            int          idx = int'($urandom_range(0, 63));
            logic [31:0] addr = (idx << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0 || !model.exists(idx)) begin
                logic [31:0] dat = $urandom;
                logic [3:0]  stb = model.exists(idx) ? 4'($urandom) : 4'hF;
                do_write(addr, dat, stb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
                check("rand_bresp", r, 2'b00);
                model[idx] = merge(model.exists(idx) ? model[idx] : 32'h0, dat, stb);
            end else begin
                do_read(addr, d, r);
                check("rand_read", {d, r}, {model[idx], 2'b00});
            end
        end

        araddr = 32'h10; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("mid_rvalid", rvalid, 1);
        #2 s_aresetn = 1'b0;
        #1 check("async_reset", {rvalid, rdata, arready}, 0);
        @(negedge clk);
        s_aresetn = 1'b1;
        @(negedge clk);
        do_read(32'h10, d, r);
        check("kept_10", d, model[4]);
        do_read(32'h20, d, r);
        check("kept_20", d, model[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
